register_file_param: RTL and testbench
======================================

Name: register_file_param

Overview:
- Parametrised general-purpose register file for the single-cycle/pipelined datapath.
- Generalises the single enable-gated register into DEPTH registers of WIDTH bits.
- Provides two read ports and one write port, a hardwired-zero register 0, and a distinguished stack-pointer register with its own reset value.
- Has selectable write-to-read bypass and selectable combinational or registered read.

Parameters:
- WIDTH, 32, data width of every register and data port.
- DEPTH, 32, number of implemented registers; legal range 2..2^ADDR_W.
- ADDR_W, 5, width of every register-address port.
- SP_INDEX, 29, index of the stack-pointer register; must be in 1..DEPTH-1.
- SP_INIT, 32'h7FFF_EFFC, reset value of register SP_INDEX. Truncated or zero-extended to WIDTH.
- BYPASS, 1, 1 = a read of the register being written returns write_data in the same cycle; 0 = returns the old contents.
- READ_REG, 0, 0 = combinational read ports; 1 = read ports registered on posedge clk (one-cycle read latency).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; state clears immediately when low.
- reg_write  input  1  write enable.
- write_reg  input  ADDR_W  write address.
- write_data  input  WIDTH  write data.
- read_reg_1  input  ADDR_W  read address, port 1.
- read_reg_2  input  ADDR_W  read address, port 2.
- read_data_1  output  WIDTH  read data, port 1.
- read_data_2  output  WIDTH  read data, port 2.

Behaviour:
- Reset (reset==0, independent of clk):
  - All registers become 0, except register SP_INDEX, which becomes SP_INIT.
  - If READ_REG=1, read_data_1 and read_data_2 also become 0.
  - Reset held low blocks all writes.
  - Deasserting reset mid-cycle has no effect until the next posedge clk.
- Write: at posedge clk, with reset==1, reg_write==1, write_reg!=0 and write_reg<DEPTH, register[write_reg] <= write_data.
  - Writes to address 0 are discarded.
  - Writes to addresses >= DEPTH are discarded.
  - No other register changes.
- Register 0 always reads 0, regardless of any write or bypass.
- A read address >= DEPTH returns 0.
- Effective read value for port k, evaluated in priority order:
  - addr==0 or addr>=DEPTH -> 0.
  - else BYPASS==1 and reg_write==1 and write_reg==addr -> write_data.
  - else register[addr].
- READ_REG=0: read_data_k equals the effective read value combinationally (zero latency).
- READ_REG=1: at each posedge clk with reset==1, read_data_k <= effective read value computed from that cycle's inputs.
  - Outputs hold between edges.
  - With BYPASS=0 and a same-cycle write/read of one address, the captured value is the pre-write contents.
- Both read ports are fully independent; reading the same address on both ports returns identical values.
- Simultaneous reset assertion and posedge clk: reset wins and no write occurs.
- Width rules:
  - Addresses are compared as unsigned ADDR_W values.
  - No arithmetic is performed; data passes unmodified.

Test Plan:
- Pulse reset low, then read regs 0, 1, 29 and 31 -> 0, 0, 32'h7FFF_EFFC, 0. With READ_REG=1, the outputs are 0 during reset.
- Write 32'hDEAD_BEEF to reg 5; next cycle read both ports at 5 -> 32'hDEAD_BEEF on both. Reg 6 remains 0.
- Write 32'h1234_5678 to reg 0 with reg_write=1, then read reg 0 -> 0, including on the bypass path in the same cycle.
- BYPASS=1, READ_REG=0: in the same cycle, write 32'hA5A5_A5A5 to reg 7 and read reg 7 on port 1 -> 32'hA5A5_A5A5 before the edge. With BYPASS=0, port 1 shows the old value 0 until after the edge.
- READ_REG=1: present read_reg_2=29 -> read_data_2 = 32'h7FFF_EFFC one edge later, not before. Assert reset mid-cycle -> read_data_2 drops to 0 immediately.
- DEPTH=16, ADDR_W=5: write 32'hFFFF_FFFF to address 20, then read address 20 -> 0. All registers 1..15 are unchanged.

Source files
------------

// File: rtl/register_file_param.sv
// ============================================================================
// Module   : register_file_param
// Purpose  : DEPTH x WIDTH register file, two read ports, one write port,
//            hardwired-zero r0, stack pointer with its own reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_param #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 32,
  parameter int               ADDR_W   = 5,
  parameter int               SP_INDEX = 29,
  parameter logic [WIDTH-1:0] SP_INIT  = 32'h7FFF_EFFC,
  parameter bit               BYPASS   = 1'b1,
  parameter bit               READ_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [WIDTH-1:0]  read_data_1,
  output logic [WIDTH-1:0]  read_data_2
);

  localparam int              c_NSLOTS = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH  = (ADDR_W + 1)'(DEPTH);

  // Every address slot exists; unimplemented ones and slot 0 read as zero,
  // so indexing with a full ADDR_W address never goes out of range.
  logic [WIDTH-1:0] w_regs [c_NSLOTS];

  generate
    for (genvar gi = 0; gi < c_NSLOTS; gi++) begin : g_slot
      if (gi >= 1 && gi < DEPTH) begin : g_impl
        localparam logic [WIDTH-1:0] c_RST = (gi == SP_INDEX) ? SP_INIT : '0;
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_q <= c_RST;
          end else if (reg_write && (write_reg == ADDR_W'(gi))) begin
            r_q <= write_data;
          end
        end

        assign w_regs[gi] = r_q;
      end else begin : g_zero
        assign w_regs[gi] = '0;
      end
    end
  endgenerate

  function automatic logic [WIDTH-1:0] f_eff(
    input logic [ADDR_W-1:0] addr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata,
    input logic [WIDTH-1:0]  stored
  );
    if (addr == '0 || {1'b0, addr} >= c_DEPTH) begin
      return '0;
    end else if (BYPASS && we && (waddr == addr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  logic [WIDTH-1:0] w_eff_1;
  logic [WIDTH-1:0] w_eff_2;

  assign w_eff_1 = f_eff(read_reg_1, reg_write, write_reg, write_data, w_regs[read_reg_1]);
  assign w_eff_2 = f_eff(read_reg_2, reg_write, write_reg, write_data, w_regs[read_reg_2]);

  generate
    if (READ_REG) begin : g_rd_reg
      logic [WIDTH-1:0] r_rd_1;
      logic [WIDTH-1:0] r_rd_2;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_rd_1 <= '0;
          r_rd_2 <= '0;
        end else begin
          r_rd_1 <= w_eff_1;
          r_rd_2 <= w_eff_2;
        end
      end

      assign read_data_1 = r_rd_1;
      assign read_data_2 = r_rd_2;
    end else begin : g_rd_comb
      assign read_data_1 = w_eff_1;
      assign read_data_2 = w_eff_2;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_register_file_param.sv
// ============================================================================
// Module   : tb_register_file_param
// Purpose  : Scoreboard bench for three register_file_param configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_param;

  localparam logic [31:0] c_SP = 32'h7FFF_EFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg_1 = '0;
  logic [4:0]  read_reg_2 = '0;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;

  always #5 clk = ~clk;

  // a: bypass, combinational read; b: no bypass, registered read;
  // c: 16 registers, no bypass, combinational read, SP at 13.
  register_file_param #(.BYPASS(1'b1), .READ_REG(1'b0)) dut_a (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(a_rd1), .read_data_2(a_rd2));

  register_file_param #(.BYPASS(1'b0), .READ_REG(1'b1)) dut_b (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(b_rd1), .read_data_2(b_rd2));

  register_file_param #(.DEPTH(16), .SP_INDEX(13), .BYPASS(1'b0), .READ_REG(1'b0)) dut_c (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(c_rd1), .read_data_2(c_rd2));

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_total  = 0;
  int   n_passed = 0;
  event chk_ev;

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      0: return a_rd1;
      1: return a_rd2;
      2: return b_rd1;
      3: return b_rd2;
      4: return c_rd1;
      default: return c_rd2;
    endcase
  endfunction

  task automatic exp_v(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic sample();
    -> chk_ev;
    #1;
  endtask

  // Monitor: drains the scoreboard whenever the stimulus marks outputs valid.
  initial begin
    exp_t e;
    logic [31:0] got;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        got = get_out(e.sel);
        n_total++;
        if (got === e.val) n_passed++;
        else $display("FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  end

  logic [31:0] model_c [16];

  initial begin
    read_reg_1 = 5'd0; read_reg_2 = 5'd29;
    @(posedge clk);
    @(negedge clk);
    exp_v(3, 32'h0, "b_rd2_in_reset"); exp_v(2, 32'h0, "b_rd1_in_reset");
    exp_v(1, c_SP, "a_sp_in_reset");
    sample();
    reset = 1'b1;
    #1;
    exp_v(3, 32'h0, "b_sp_not_before_edge");
    exp_v(0, 32'h0, "a_r0_after_reset");  exp_v(1, c_SP, "a_r29_sp");
    exp_v(4, 32'h0, "c_r0_after_reset");  exp_v(5, 32'h0, "c_r29_out_of_range");
    sample();
    @(posedge clk); #1;
    exp_v(3, c_SP, "b_sp_after_edge"); exp_v(2, 32'h0, "b_r0_after_edge");
    sample();

    @(negedge clk); read_reg_1 = 5'd1; read_reg_2 = 5'd31; #1;
    exp_v(0, 32'h0, "a_r1_reset"); exp_v(1, 32'h0, "a_r31_reset");
    exp_v(4, 32'h0, "c_r1_reset"); exp_v(5, 32'h0, "c_r31_reset");
    sample();

    // Write DEADBEEF to r5, observe bypass and latency differences.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
    read_reg_1 = 5'd5; read_reg_2 = 5'd6; #1;
    exp_v(0, 32'hDEAD_BEEF, "a_bypass_r5"); exp_v(1, 32'h0, "a_r6_zero");
    exp_v(4, 32'h0, "c_nobypass_r5_old");
    sample();
    @(posedge clk); #1;
    exp_v(2, 32'h0, "b_r5_prewrite_capture"); exp_v(4, 32'hDEAD_BEEF, "c_r5_after_edge");
    sample();
    @(negedge clk); reg_write = 1'b0; read_reg_1 = 5'd5; read_reg_2 = 5'd5; #1;
    exp_v(0, 32'hDEAD_BEEF, "a_r5_p1"); exp_v(1, 32'hDEAD_BEEF, "a_r5_p2");
    exp_v(4, 32'hDEAD_BEEF, "c_r5_p1"); exp_v(5, 32'hDEAD_BEEF, "c_r5_p2");
    sample();
    @(posedge clk); #1;
    exp_v(2, 32'hDEAD_BEEF, "b_r5_p1"); exp_v(3, 32'hDEAD_BEEF, "b_r5_p2");
    sample();

    // Writes to r0 are discarded, including on the bypass path.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h1234_5678;
    read_reg_1 = 5'd0; read_reg_2 = 5'd0; #1;
    exp_v(0, 32'h0, "a_r0_bypass_p1"); exp_v(1, 32'h0, "a_r0_bypass_p2");
    exp_v(4, 32'h0, "c_r0_write");
    sample();
    @(posedge clk); #1;
    exp_v(2, 32'h0, "b_r0_p1"); exp_v(3, 32'h0, "b_r0_p2"); exp_v(0, 32'h0, "a_r0_after");
    sample();

    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd7; write_data = 32'hA5A5_A5A5;
    read_reg_1 = 5'd7; read_reg_2 = 5'd5; #1;
    exp_v(0, 32'hA5A5_A5A5, "a_bypass_r7"); exp_v(1, 32'hDEAD_BEEF, "a_r5_during_w7");
    exp_v(4, 32'h0, "c_r7_old");
    sample();
    @(posedge clk); #1;
    exp_v(4, 32'hA5A5_A5A5, "c_r7_after_edge"); exp_v(2, 32'h0, "b_r7_prewrite");
    exp_v(3, 32'hDEAD_BEEF, "b_r5_p2_again");
    sample();
    @(negedge clk); reg_write = 1'b0;
    @(posedge clk); #1;
    exp_v(2, 32'hA5A5_A5A5, "b_r7_next_edge");
    sample();

    // Address 20 is out of range for the 16-deep instance only.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd20; write_data = 32'hFFFF_FFFF;
    read_reg_1 = 5'd20; read_reg_2 = 5'd0;
    @(negedge clk); reg_write = 1'b0; #1;
    exp_v(0, 32'hFFFF_FFFF, "a_r20_written"); exp_v(4, 32'h0, "c_r20_out_of_range");
    sample();
    for (int i = 0; i < 16; i++) model_c[i] = 32'h0;
    model_c[5] = 32'hDEAD_BEEF; model_c[7] = 32'hA5A5_A5A5; model_c[13] = c_SP;
    for (int i = 1; i < 16; i++) begin
      read_reg_1 = 5'(i); #1;
      exp_v(4, model_c[i], $sformatf("c_r%0d_unchanged", i));
      sample();
    end

    // Asynchronous reset mid-cycle clears registered outputs immediately.
    @(negedge clk); read_reg_1 = 5'd5; read_reg_2 = 5'd29;
    @(posedge clk); #1;
    exp_v(3, c_SP, "b_sp_before_async_rst"); exp_v(2, 32'hDEAD_BEEF, "b_r5_before_async_rst");
    sample();
    #2; reset = 1'b0; #1;
    exp_v(3, 32'h0, "b_rd2_async_rst"); exp_v(2, 32'h0, "b_rd1_async_rst");
    exp_v(0, 32'h0, "a_r5_async_rst");   exp_v(1, c_SP, "a_sp_async_rst");
    sample();

    // Writes are blocked while reset is held low.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h1111_1111;
    @(posedge clk); #1;
    exp_v(4, 32'h0, "c_write_blocked_in_reset"); exp_v(2, 32'h0, "b_held_in_reset");
    sample();
    @(negedge clk); reg_write = 1'b0; reset = 1'b1; #1;
    exp_v(0, 32'h0, "a_r5_no_write_in_reset"); exp_v(4, 32'h0, "c_r5_no_write_in_reset");
    sample();

    #5;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

`default_nettype wire
